// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, channel slicing and
// counter-region helpers used by the timing generator and any later overlays.
package vga_pkg;

  localparam int DEF_COLOR_W  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Widest colour channel the slice helper handles.
  localparam int MAX_COLOR_W = 16;

  typedef logic [3*MAX_COLOR_W-1:0] pix_wide_t;
  typedef logic [MAX_COLOR_W-1:0]   chan_wide_t;

  // Channel index within a packed {R,G,B} pixel, counted from the LSB end.
  typedef enum logic [1:0] {
    CH_BLUE  = 2'd0,
    CH_GREEN = 2'd1,
    CH_RED   = 2'd2
  } chan_e;

  function automatic chan_wide_t chan_slice(pix_wide_t pix, int cw, chan_e ch);
    pix_wide_t  sh;
    chan_wide_t mask;
    sh   = pix >> (int'(ch) * cw);
    mask = '1;
    mask = mask >> (MAX_COLOR_W - cw);
    return sh[MAX_COLOR_W-1:0] & mask;
  endfunction

  // True when v lies in the half-open window [lo, lo+len).
  function automatic logic in_region(int unsigned v, int unsigned lo, int unsigned len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters with active, sync and frame-start decode.
// Counters are held at (0,0) while en_i is low.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  output logic [HW-1:0] hcnt_o,
  output logic [VW-1:0] vcnt_o,
  output logic          active_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          frame_start_o
);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!en_i) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (hcnt_q == HW'(H_TOTAL - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VW'(V_TOTAL - 1)) ? '0 : vcnt_q + 1'b1;
    end else begin
      hcnt_d = hcnt_q + 1'b1;
    end
  end

  assign hcnt_o   = hcnt_q;
  assign vcnt_o   = vcnt_q;
  assign active_o = in_region(32'(hcnt_q), 0, H_ACTIVE) &&
                    in_region(32'(vcnt_q), 0, V_ACTIVE);
  assign hsync_o  = in_region(32'(hcnt_q), H_ACTIVE + H_FP, H_SYNC);
  assign vsync_o  = in_region(32'(vcnt_q), V_ACTIVE + V_FP, V_SYNC);

  // Vertical blanking begins on the first clock of line V_ACTIVE.
  assign frame_start_o = en_i && (hcnt_q == '0) && (vcnt_q == VW'(V_ACTIVE));

endmodule

// File: rtl/vga_stream_out.sv
// VGA output stage: pulls {R,G,B} pixels from a stream during active video and
// drives registered colour/sync pins, with sticky underflow and SOF-alignment flags.
module vga_stream_out
  import vga_pkg::*;
#(
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic                 en,
  input  logic [3*COLOR_W-1:0] pix_data,
  input  logic                 pix_sof,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic                 frame_start,
  output logic [COLOR_W-1:0]   vga_port_red,
  output logic [COLOR_W-1:0]   vga_port_green,
  output logic [COLOR_W-1:0]   vga_port_blue,
  output logic                 vga_port_hs,
  output logic                 vga_port_vs,
  output logic                 underflow,
  output logic                 sync_err,
  input  logic                 err_clr
);

  localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   HW      = $clog2(H_TOTAL);
  localparam int   VW      = $clog2(V_TOTAL);
  localparam logic HS_ON   = 1'(HS_POL);
  localparam logic VS_ON   = 1'(VS_POL);

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          active, hsync, vsync;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk_clk),
    .rst           (reset_reset),
    .en_i          (en),
    .hcnt_o        (hcnt),
    .vcnt_o        (vcnt),
    .active_o      (active),
    .hsync_o       (hsync),
    .vsync_o       (vsync),
    .frame_start_o (frame_start)
  );

  // Stream handshake: a pixel moves on a rising clock edge iff pix_valid && pix_ready
  // in the preceding cycle. pix_ready depends only on registered counters, en and reset,
  // never on pix_valid; the source may raise or drop pix_valid at any time.
  logic transfer, at_origin;
  assign pix_ready = active && en && !reset_reset;
  assign transfer  = pix_valid && pix_ready;
  assign at_origin = (hcnt == '0) && (vcnt == '0);

  logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic               hs_q, hs_d, vs_q, vs_d;
  logic               underflow_q, underflow_d, sync_err_q, sync_err_d;
  logic               uf_set, se_set;

  assign uf_set = active && en && !pix_valid;
  assign se_set = transfer && (pix_sof != at_origin);

  always_comb begin
    red_d       = '0;
    green_d     = '0;
    blue_d      = '0;
    hs_d        = ~HS_ON;
    vs_d        = ~VS_ON;
    underflow_d = underflow_q;
    sync_err_d  = sync_err_q;
    if (transfer) begin
      red_d   = COLOR_W'(chan_slice(pix_wide_t'(pix_data), COLOR_W, CH_RED));
      green_d = COLOR_W'(chan_slice(pix_wide_t'(pix_data), COLOR_W, CH_GREEN));
      blue_d  = COLOR_W'(chan_slice(pix_wide_t'(pix_data), COLOR_W, CH_BLUE));
    end
    if (en && hsync) hs_d = HS_ON;
    if (en && vsync) vs_d = VS_ON;
    // A new error in the same cycle as err_clr must not be lost.
    if (uf_set)       underflow_d = 1'b1;
    else if (err_clr) underflow_d = 1'b0;
    if (se_set)       sync_err_d  = 1'b1;
    else if (err_clr) sync_err_d  = 1'b0;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      hs_q        <= ~HS_ON;
      vs_q        <= ~VS_ON;
      underflow_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      underflow_q <= underflow_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign vga_port_red   = red_q;
  assign vga_port_green = green_q;
  assign vga_port_blue  = blue_q;
  assign vga_port_hs    = hs_q;
  assign vga_port_vs    = vs_q;
  assign underflow      = underflow_q;
  assign sync_err       = sync_err_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out in a reduced 16x4 configuration with 8-bit colour and
// active-high hsync; predicted pin words are queued per cycle and compared a clock later.
module tb_vga_stream_out;

  localparam int CW  = 8;
  localparam int HA  = 16;
  localparam int HFP = 16;
  localparam int HSY = 96;
  localparam int HBP = 48;
  localparam int VA  = 4;
  localparam int VFP = 10;
  localparam int VSY = 2;
  localparam int VBP = 33;
  localparam int HT  = 176;
  localparam int VT  = 49;

  logic          clk = 1'b0;
  logic          rst, en, pix_sof, pix_valid, err_clr;
  logic [3*CW-1:0] pix_data;
  logic          pix_ready, frame_start, hs, vs, underflow, sync_err;
  logic [CW-1:0] red, green, blue;

  vga_stream_out #(
    .COLOR_W (CW), .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
    .HS_POL (1), .VS_POL (0)
  ) dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .en             (en),
    .pix_data       (pix_data),
    .pix_sof        (pix_sof),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .frame_start    (frame_start),
    .vga_port_red   (red),
    .vga_port_green (green),
    .vga_port_blue  (blue),
    .vga_port_hs    (hs),
    .vga_port_vs    (vs),
    .underflow      (underflow),
    .sync_err       (sync_err),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic [25:0] exp_q[$];
  int   m_h, m_v;
  logic exp_uf, exp_se, fs_now;
  bit   sof_auto, rand_data;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(string tag);
    check_eq({tag, "_rgb"}, 32'({red, green, blue}), 32'h0);
    check_eq({tag, "_hs"}, 32'(hs), 32'h0);
    check_eq({tag, "_vs"}, 32'(vs), 32'h1);
    check_eq({tag, "_fs"}, 32'(frame_start), 32'h0);
    check_eq({tag, "_uf"}, 32'(underflow), 32'h0);
    check_eq({tag, "_se"}, 32'(sync_err), 32'h0);
    check_eq({tag, "_ready"}, 32'(pix_ready), 32'h0);
  endtask

  // One pixel clock: drive inputs, predict, clock, compare, advance the model.
  task automatic step();
    logic org, act, rdy, xfer, hsr, vsr;
    logic [25:0] e, got;
    if (sof_auto)  pix_sof = (m_h == 0) && (m_v == 0);
    if (rand_data) pix_data = 24'($urandom);
    #1;
    org  = (m_h == 0) && (m_v == 0);
    act  = (m_h < HA) && (m_v < VA);
    rdy  = act && en;
    xfer = rdy && pix_valid;
    hsr  = (m_h >= HA + HFP) && (m_h < HA + HFP + HSY);
    vsr  = (m_v >= VA + VFP) && (m_v < VA + VFP + VSY);
    fs_now = frame_start;
    check_eq("ready", 32'(pix_ready), 32'(rdy));
    check_eq("frame_start", 32'(frame_start), 32'((m_h == 0) && (m_v == VA) && en));
    e = {(xfer ? pix_data : 24'h0), en && hsr, !(en && vsr)};
    exp_q.push_back(e);
    if (rdy && !pix_valid) exp_uf = 1'b1;
    else if (err_clr)      exp_uf = 1'b0;
    if (xfer && (pix_sof != org)) exp_se = 1'b1;
    else if (err_clr)             exp_se = 1'b0;
    @(posedge clk);
    #1;
    got = {red, green, blue, hs, vs};
    if (exp_q.size() == 0) check_eq("queue_empty", 32'h1, 32'h0);
    else check_eq("pins", 32'(got), 32'(exp_q.pop_front()));
    check_eq("underflow", 32'(underflow), 32'(exp_uf));
    check_eq("sync_err", 32'(sync_err), 32'(exp_se));
    if (!en) begin
      m_h = 0;
      m_v = 0;
    end else if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
  endtask

  task automatic run_to(int h, int v);
    int n = 0;
    while (!((m_h == h) && (m_v == v)) && n < 20000) begin
      step();
      n++;
    end
    check_eq("run_to", 32'((m_h == h) && (m_v == v)), 32'h1);
  endtask

  initial begin
    int  n;
    bit  seen;
    rst = 1'b1; en = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0; err_clr = 1'b0;
    pix_data = '0; sof_auto = 1'b1; rand_data = 1'b1;
    m_h = 0; m_v = 0; exp_uf = 1'b0; exp_se = 1'b0; fs_now = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    en = 1'b1;
    pix_valid = 1'b1;

    // Channel mapping: R in MSBs.
    rand_data = 1'b0;
    pix_data = 24'hFF0000; step();
    check_eq("first_red", 32'(red), 32'hFF);
    check_eq("first_gb", 32'({green, blue}), 32'h0);
    pix_data = 24'h00A500; step();
    check_eq("green_map", 32'(green), 32'hA5);
    pix_data = 24'h00003C; step();
    check_eq("blue_map", 32'(blue), 32'h3C);
    rand_data = 1'b1;

    // Three-cycle source underflow mid-line.
    run_to(10, 2);
    pix_valid = 1'b0;
    repeat (3) step();
    check_eq("drop_black", 32'({red, green, blue}), 32'h0);
    pix_valid = 1'b1;
    check_eq("uf_set", 32'(underflow), 32'h1);
    run_to(0, 10);
    check_eq("uf_sticky", 32'(underflow), 32'h1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check_eq("uf_cleared", 32'(underflow), 32'h0);

    // Misplaced SOF, then a new error colliding with err_clr.
    run_to(5, 0);
    sof_auto = 1'b0; pix_sof = 1'b1; step(); sof_auto = 1'b1;
    check_eq("se_set", 32'(sync_err), 32'h1);
    run_to(7, 1);
    sof_auto = 1'b0; pix_sof = 1'b1; err_clr = 1'b1; step();
    err_clr = 1'b0; sof_auto = 1'b1;
    check_eq("se_set_wins", 32'(sync_err), 32'h1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check_eq("se_cleared", 32'(sync_err), 32'h0);

    // Missing SOF at the origin.
    run_to(0, 0);
    sof_auto = 1'b0; pix_sof = 1'b0; step(); sof_auto = 1'b1;
    check_eq("se_missing_sof", 32'(sync_err), 32'h1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check_eq("se_cleared2", 32'(sync_err), 32'h0);

    // Disable mid-frame, then measure time to the next frame_start.
    run_to(3, 2);
    en = 1'b0;
    repeat (20) step();
    en = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      step();
      if (fs_now) seen = 1'b1;
      else n++;
    end
    check_eq("fs_latency", 32'(n), 32'(VA * HT));

    // Asynchronous reset mid-line with a flag set.
    run_to(8, 2);
    pix_valid = 1'b0; step(); pix_valid = 1'b1;
    check_eq("uf_before_rst", 32'(underflow), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset("async_reset");
    @(posedge clk);
    #1;
    check_reset("reset_held");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
